spi_cmd_controller: RTL

//  Command sequencer between the SPI slave byte interface and the FFT core.
//  - Parses byte frames (one frame = one slave_sel low period) into opcodes.
//  - Loads the FFT sample RAM, starts the FFT, streams results back, reports status.
//  - Drives the interface's next-TX byte.

---
 rtl/spi_cmd_pkg.sv | 45 ++++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_cmd_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command sequencer: opcodes, FSM states,
// status-byte bit positions and the debug view exported by the top.
package spi_cmd_pkg;

  typedef enum logic [7:0] {
    OP_WRITE  = 8'h01,
    OP_START  = 8'h02,
    OP_READ   = 8'h03,
    OP_STATUS = 8'h04
  } opcode_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_W_ADDR,
    ST_W_MSB,
    ST_W_LSB,
    ST_R_ADDR,
    ST_R_LSB,
    ST_R_MSB,
    ST_DRAIN
  } state_e;

  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_DONE_BIT = 6;
  localparam int STAT_ERR_BIT  = 5;

  typedef struct packed {
    state_e state;
    logic   sel_active;
    logic   byte_level;
    logic   byte_fall;
  } dbg_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                             input logic err);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_DONE_BIT] = done;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous level plus rise/fall pulses.
// Flops reset to 0 so a level already low at reset release yields no fall.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_cmd_controller.sv
// Command sequencer between the SPI slave byte interface and the FFT core.
// Optional build macro SPI_CMD_ECHO_EN: echo received data bytes during WRITE frames.
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sel,
  input  logic              spi_byte_done,
  input  logic [7:0]        spi_rx_byte,
  output logic [7:0]        spi_tx_byte,
  output logic              smp_wr_en,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [15:0]       smp_wr_data,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [15:0]       res_rd_data,
  output logic              fft_start,
  input  logic              fft_busy,
  input  logic              fft_done,
  output logic              err,
  output dbg_t              dbg
);

  logic sel_level, sel_rise, sel_fall;
  logic bd_level, bd_rise, bd_fall;
  logic byte_ev;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sel_sync (
    .clk(clk), .rst_n(reset), .async_in(spi_sel),
    .level(sel_level), .rise(sel_rise), .fall(sel_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_bd_sync (
    .clk(clk), .rst_n(reset), .async_in(spi_byte_done),
    .level(bd_level), .rise(bd_rise), .fall(bd_fall)
  );

  // Bytes only count while the frame is selected; the rx byte is stable here.
  assign byte_ev = bd_rise & ~sel_level;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        msb_q, msb_d;
  logic [7:0]        lsb_hold_q, lsb_hold_d;
  logic [7:0]        tx_q, tx_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              smp_wr_en_q, smp_wr_en_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [15:0]       smp_wr_data_q, smp_wr_data_d;
  logic              res_rd_en_q, res_rd_en_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic              fft_start_q, fft_start_d;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    msb_d         = msb_q;
    lsb_hold_d    = lsb_hold_q;
    tx_d          = tx_q;
    err_d         = err_q;
    done_d        = done_q;
    rd_pend_d     = res_rd_en_q;
    smp_wr_en_d   = 1'b0;
    smp_addr_d    = smp_addr_q;
    smp_wr_data_d = smp_wr_data_q;
    res_rd_en_d   = 1'b0;
    res_addr_d    = res_addr_q;
    fft_start_d   = 1'b0;

    // Result RAM answers one cycle after the strobe; MSB goes out now, LSB next byte.
    if (rd_pend_q && state_q == ST_R_LSB) begin
      tx_d       = res_rd_data[15:8];
      lsb_hold_d = res_rd_data[7:0];
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = status_byte(fft_busy, done_q, err_q);
        if (sel_fall) state_d = ST_OPCODE;
      end
      ST_OPCODE: if (byte_ev) begin
        tx_d = 8'h00;
        case (spi_rx_byte)
          OP_WRITE: state_d = ST_W_ADDR;
          OP_READ:  state_d = ST_R_ADDR;
          OP_START: begin
            if (!fft_busy) begin
              fft_start_d = 1'b1;
              done_d      = 1'b0;
            end else begin
              err_d = 1'b1;
            end
            state_d = ST_DRAIN;
          end
          OP_STATUS: begin
            err_d   = 1'b0;
            state_d = ST_DRAIN;
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        endcase
      end
      ST_W_ADDR: if (byte_ev) begin
        ptr_d   = ADDR_W'(spi_rx_byte);
        state_d = ST_W_MSB;
      end
      ST_W_MSB: if (byte_ev) begin
        msb_d   = spi_rx_byte;
`ifdef SPI_CMD_ECHO_EN
        tx_d    = spi_rx_byte;
`else
        tx_d    = 8'h00;
`endif
        state_d = ST_W_LSB;
      end
      ST_W_LSB: if (byte_ev) begin
        smp_wr_en_d   = 1'b1;
        smp_addr_d    = ptr_q;
        smp_wr_data_d = {msb_q, spi_rx_byte};
        ptr_d         = ptr_q + ADDR_W'(1);
`ifdef SPI_CMD_ECHO_EN
        tx_d          = spi_rx_byte;
`else
        tx_d          = 8'h00;
`endif
        state_d       = ST_W_MSB;
      end
      ST_R_ADDR: if (byte_ev) begin
        res_rd_en_d = 1'b1;
        res_addr_d  = ADDR_W'(spi_rx_byte);
        ptr_d       = ADDR_W'(spi_rx_byte) + ADDR_W'(1);
        state_d     = ST_R_LSB;
      end
      ST_R_LSB: if (byte_ev) begin
        tx_d    = lsb_hold_q;
        state_d = ST_R_MSB;
      end
      ST_R_MSB: if (byte_ev) begin
        res_rd_en_d = 1'b1;
        res_addr_d  = ptr_q;
        ptr_d       = ptr_q + ADDR_W'(1);
        state_d     = ST_R_LSB;
      end
      ST_DRAIN: tx_d = 8'h00;
      default:  state_d = ST_IDLE;
    endcase

    // Deselect aborts the frame: a held MSB is simply never written, reads are dropped.
    if (sel_rise) begin
      state_d     = ST_IDLE;
      rd_pend_d   = 1'b0;
      res_rd_en_d = 1'b0;
    end

    if (fft_done) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      msb_q         <= 8'h00;
      lsb_hold_q    <= 8'h00;
      tx_q          <= 8'h00;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      rd_pend_q     <= 1'b0;
      smp_wr_en_q   <= 1'b0;
      smp_addr_q    <= '0;
      smp_wr_data_q <= 16'h0000;
      res_rd_en_q   <= 1'b0;
      res_addr_q    <= '0;
      fft_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      msb_q         <= msb_d;
      lsb_hold_q    <= lsb_hold_d;
      tx_q          <= tx_d;
      err_q         <= err_d;
      done_q        <= done_d;
      rd_pend_q     <= rd_pend_d;
      smp_wr_en_q   <= smp_wr_en_d;
      smp_addr_q    <= smp_addr_d;
      smp_wr_data_q <= smp_wr_data_d;
      res_rd_en_q   <= res_rd_en_d;
      res_addr_q    <= res_addr_d;
      fft_start_q   <= fft_start_d;
    end
  end

  assign spi_tx_byte    = tx_q;
  assign smp_wr_en      = smp_wr_en_q;
  assign smp_addr       = smp_addr_q;
  assign smp_wr_data    = smp_wr_data_q;
  assign res_rd_en      = res_rd_en_q;
  assign res_addr       = res_addr_q;
  assign fft_start      = fft_start_q;
  assign err            = err_q;
  assign dbg.state      = state_q;
  assign dbg.sel_active = ~sel_level;
  assign dbg.byte_level = bd_level;
  assign dbg.byte_fall  = bd_fall;

endmodule
